// File: rtl/mdio_pkg.sv
// Shared constants for the MDIO management master: state codes, frame field codes and lengths.
package mdio_pkg;

   localparam int unsigned CNT_W     = 6;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned HDR_BITS  = 14;
   localparam int unsigned TA_BITS   = 2;
   localparam int unsigned DATA_BITS = 16;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PRE  = 3'd1;
   localparam logic [2:0] S_HDR  = 3'd2;
   localparam logic [2:0] S_TA   = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [1:0] ST_CODE = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;
   localparam logic [1:0] TA_WR   = 2'b10;

   // ST, OP, PHYAD, REGAD packed MSB first, as shifted onto the line
   function automatic logic [HDR_BITS-1:0] hdr_word(input logic             wr,
                                                    input logic [ADDR_W-1:0] phyad,
                                                    input logic [ADDR_W-1:0] regad);
      return {ST_CODE, (wr ? OP_WR : OP_RD), phyad, regad};
   endfunction

endpackage

// File: rtl/mdio_mgmt_ctrl_if.sv
// Requester and MDIO line bundle; master = controller side, slave = requesters/PHY side.
interface mdio_mgmt_ctrl_if;

   logic                          REQ0_VALID;
   logic                          REQ0_WR;
   logic [mdio_pkg::ADDR_W-1:0]   REQ0_PHYAD;
   logic [mdio_pkg::ADDR_W-1:0]   REQ0_REGAD;
   logic [mdio_pkg::DATA_W-1:0]   REQ0_WDATA;
   logic                          REQ0_DONE;
   logic                          REQ1_VALID;
   logic                          REQ1_WR;
   logic [mdio_pkg::ADDR_W-1:0]   REQ1_PHYAD;
   logic [mdio_pkg::ADDR_W-1:0]   REQ1_REGAD;
   logic [mdio_pkg::DATA_W-1:0]   REQ1_WDATA;
   logic                          REQ1_DONE;
   logic [mdio_pkg::DATA_W-1:0]   RDATA;
   logic                          BUSY;
   logic                          MDIO_OUT;
   logic                          MDIO_OE;
   logic                          MDIO_IN;

   modport master (
      input  REQ0_VALID, REQ0_WR, REQ0_PHYAD, REQ0_REGAD, REQ0_WDATA,
      input  REQ1_VALID, REQ1_WR, REQ1_PHYAD, REQ1_REGAD, REQ1_WDATA,
      input  MDIO_IN,
      output REQ0_DONE, REQ1_DONE, RDATA, BUSY, MDIO_OUT, MDIO_OE
   );

   modport slave (
      output REQ0_VALID, REQ0_WR, REQ0_PHYAD, REQ0_REGAD, REQ0_WDATA,
      output REQ1_VALID, REQ1_WR, REQ1_PHYAD, REQ1_REGAD, REQ1_WDATA,
      output MDIO_IN,
      input  REQ0_DONE, REQ1_DONE, RDATA, BUSY, MDIO_OUT, MDIO_OE
   );

endinterface

// File: rtl/mdio_rr_arbiter.sv
// Two-way round-robin arbiter; last_grant_q also names the owner of the frame in flight.
module mdio_rr_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       load,
   output logic       gnt_idx_c,
   output logic       last_grant_q
);

   // On contention the requester that did not win last time goes first
   always_comb begin
      gnt_idx_c = last_grant_q;
      case (req)
         2'b01:   gnt_idx_c = 1'b0;
         2'b10:   gnt_idx_c = 1'b1;
         2'b11:   gnt_idx_c = ~last_grant_q;
         default: gnt_idx_c = last_grant_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)    last_grant_q <= 1'b1;
      else if (load) last_grant_q <= gnt_idx_c;
   end

endmodule

// File: rtl/mdio_mgmt_ctrl.sv
// MDIO Clause-22 management master: arbitrates two requesters and serializes one frame at a time.
module mdio_mgmt_ctrl
   import mdio_pkg::*;
#(
   parameter int unsigned PRE_LEN = 32
) (
   input  logic                MDC,
   input  logic                RESET,
   mdio_mgmt_ctrl_if.master    bus
);

   localparam logic [CNT_W-1:0] PRE_LAST  = (PRE_LEN == 0) ? '0 : CNT_W'(PRE_LEN - 1);
   localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
   localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(TA_BITS - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
   localparam logic [2:0]       FIRST_ST  = (PRE_LEN == 0) ? S_HDR : S_PRE;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] phyad_q, phyad_d, regad_q, regad_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, cap_q, cap_d, rdata_q, rdata_d;
   logic              busy_q, busy_d, done0_q, done0_d, done1_q, done1_d;
   logic              out_q, out_d, oe_q, oe_d;
   logic [HDR_BITS-1:0] hdr_d;
   logic [3:0]        hdr_idx, dat_idx;
   logic              grant_c, gnt_idx_c, owner_q;

   assign grant_c = (state_q == S_IDLE) && (bus.REQ0_VALID || bus.REQ1_VALID);

   mdio_rr_arbiter u_arb (
      .clk          (MDC),
      .rst_n        (RESET),
      .req          ({bus.REQ1_VALID, bus.REQ0_VALID}),
      .load         (grant_c),
      .gnt_idx_c    (gnt_idx_c),
      .last_grant_q (owner_q)
   );

   // Next state/counter first, then the line bit for the cycle that the next state occupies
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      wr_d    = wr_q;
      phyad_d = phyad_q;
      regad_d = regad_q;
      wdata_d = wdata_q;
      cap_d   = cap_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (grant_c) begin
               state_d = FIRST_ST;
               wr_d    = gnt_idx_c ? bus.REQ1_WR    : bus.REQ0_WR;
               phyad_d = gnt_idx_c ? bus.REQ1_PHYAD : bus.REQ0_PHYAD;
               regad_d = gnt_idx_c ? bus.REQ1_REGAD : bus.REQ0_REGAD;
               wdata_d = gnt_idx_c ? bus.REQ1_WDATA : bus.REQ0_WDATA;
            end
         end
         S_PRE: if (cnt_q == PRE_LAST) begin state_d = S_HDR;  cnt_d = '0; end
         S_HDR: if (cnt_q == HDR_LAST) begin state_d = S_TA;   cnt_d = '0; end
         S_TA:  if (cnt_q == TA_LAST)  begin state_d = S_DATA; cnt_d = '0; end
         S_DATA: begin
            if (!wr_q) cap_d = {cap_q[DATA_W-2:0], bus.MDIO_IN};
            if (cnt_q == DATA_LAST) begin
               state_d = S_DONE;
               cnt_d   = '0;
               if (!wr_q) rdata_d = {cap_q[DATA_W-2:0], bus.MDIO_IN};
            end
         end
         S_DONE: begin state_d = S_IDLE; cnt_d = '0; end
         default: begin state_d = S_IDLE; cnt_d = '0; end
      endcase

      hdr_d   = hdr_word(wr_d, phyad_d, regad_d);
      hdr_idx = 4'(4'd13 - cnt_d[3:0]);
      dat_idx = ~cnt_d[3:0];
      out_d   = 1'b1;
      oe_d    = 1'b0;
      case (state_d)
         S_PRE:  oe_d = 1'b1;
         S_HDR:  begin oe_d = 1'b1; out_d = hdr_d[hdr_idx]; end
         S_TA:   begin oe_d = wr_d; out_d = wr_d ? TA_WR[~cnt_d[0]] : 1'b1; end
         S_DATA: begin oe_d = wr_d; out_d = wr_d ? wdata_d[dat_idx] : 1'b1; end
         default: begin oe_d = 1'b0; out_d = 1'b1; end
      endcase

      busy_d  = (state_d != S_IDLE);
      done0_d = (state_d == S_DONE) && !owner_q;
      done1_d = (state_d == S_DONE) &&  owner_q;
   end

   always_ff @(posedge MDC) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         phyad_q <= '0;
         regad_q <= '0;
         wdata_q <= '0;
         cap_q   <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         out_q   <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         phyad_q <= phyad_d;
         regad_q <= regad_d;
         wdata_q <= wdata_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
      end
   end

   assign bus.REQ0_DONE = done0_q;
   assign bus.REQ1_DONE = done1_q;
   assign bus.RDATA     = rdata_q;
   assign bus.BUSY      = busy_q;
   assign bus.MDIO_OUT  = out_q;
   assign bus.MDIO_OE   = oe_q;

endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// Directed bench for mdio_mgmt_ctrl: one instance with a 32-bit preamble, one with none.
module tb_mdio_mgmt_ctrl;

   logic MDC = 1'b0;
   logic RESET;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   logic        c_out  [0:71];
   logic        c_oe   [0:71];
   logic        c_d0   [0:71];
   logic        c_d1   [0:71];
   logic        c_busy [0:71];
   logic [15:0] c_rdata[0:71];

   mdio_mgmt_ctrl_if b32 ();
   mdio_mgmt_ctrl_if b0 ();

   mdio_mgmt_ctrl #(.PRE_LEN(32)) u_dut32 (.MDC(MDC), .RESET(RESET), .bus(b32.master));
   mdio_mgmt_ctrl #(.PRE_LEN(0))  u_dut0  (.MDC(MDC), .RESET(RESET), .bus(b0.master));

   always #5 MDC = ~MDC;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Expected 32-bit frame as seen on MDIO_OUT (reads leave the line at 1 after REGAD)
   function automatic logic [31:0] frame_word(input logic wr, input logic [4:0] phy,
                                              input logic [4:0] rg, input logic [15:0] d);
      return {2'b01, (wr ? 2'b01 : 2'b10), phy, rg, (wr ? 2'b10 : 2'b11), (wr ? d : 16'hFFFF)};
   endfunction

   // Records n cycles after a grant edge; optionally plays read data back on MDIO_IN
   task automatic capture(input bit sel, input int n, input bit rd, input logic [15:0] rword);
      for (int j = 0; j < n; j++) begin
         @(negedge MDC);
         if (!sel) begin
            c_out[j] = b32.MDIO_OUT; c_oe[j] = b32.MDIO_OE; c_d0[j] = b32.REQ0_DONE;
            c_d1[j] = b32.REQ1_DONE; c_busy[j] = b32.BUSY; c_rdata[j] = b32.RDATA;
            if (rd && j >= 48 && j < 64) b32.MDIO_IN = rword[63-j];
            if (b32.REQ0_DONE) b32.REQ0_VALID = 1'b0;
            if (b32.REQ1_DONE) b32.REQ1_VALID = 1'b0;
         end else begin
            c_out[j] = b0.MDIO_OUT; c_oe[j] = b0.MDIO_OE; c_d0[j] = b0.REQ0_DONE;
            c_d1[j] = b0.REQ1_DONE; c_busy[j] = b0.BUSY; c_rdata[j] = b0.RDATA;
            if (b0.REQ0_DONE) b0.REQ0_VALID = 1'b0;
            if (b0.REQ1_DONE) b0.REQ1_VALID = 1'b0;
         end
      end
      b32.MDIO_IN = 1'b1;
   endtask

   // Waits (bounded) for up to two DONE pulses on the PRE_LEN=32 instance, recording who finished
   task automatic wait_dones(input int need, output int first, output int second);
      int got = 0;
      first = -1; second = -1;
      for (int c = 0; c < 400 && got < need; c++) begin
         @(negedge MDC);
         if (b32.REQ0_DONE) begin
            if (got == 0) first = 0; else second = 0;
            got++; b32.REQ0_VALID = 1'b0;
         end
         if (b32.REQ1_DONE) begin
            if (got == 0) first = 1; else second = 1;
            got++; b32.REQ1_VALID = 1'b0;
         end
      end
   endtask

   task automatic test_reset;
      RESET = 1'b0;
      b32.REQ0_VALID = 1'b1; b32.REQ1_VALID = 1'b1;
      b0.REQ0_VALID  = 1'b1; b0.REQ1_VALID  = 1'b1;
      repeat (3) @(posedge MDC);
      @(negedge MDC);
      vec_cnt++; if (b32.MDIO_OE !== 1'b0)  begin err_cnt++; $display("FAIL reset_oe got=%b exp=0", b32.MDIO_OE); end
      vec_cnt++; if (b32.MDIO_OUT !== 1'b1) begin err_cnt++; $display("FAIL reset_out got=%b exp=1", b32.MDIO_OUT); end
      vec_cnt++; if (b32.BUSY !== 1'b0)     begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", b32.BUSY); end
      vec_cnt++; if ({b32.REQ0_DONE, b32.REQ1_DONE} !== 2'b00) begin err_cnt++; $display("FAIL reset_done got=%b%b exp=00", b32.REQ0_DONE, b32.REQ1_DONE); end
      vec_cnt++; if (b32.RDATA !== 16'h0)   begin err_cnt++; $display("FAIL reset_rdata got=%h exp=0000", b32.RDATA); end
      vec_cnt++; if ({b0.MDIO_OE, b0.MDIO_OUT, b0.BUSY} !== 3'b010) begin err_cnt++; $display("FAIL reset_pre0 oe/out/busy got=%b%b%b exp=010", b0.MDIO_OE, b0.MDIO_OUT, b0.BUSY); end
      b32.REQ0_VALID = 1'b0; b32.REQ1_VALID = 1'b0;
      b0.REQ0_VALID  = 1'b0; b0.REQ1_VALID  = 1'b0;
      @(posedge MDC); #1 RESET = 1'b1;
   endtask

   task automatic test_write;
      logic [31:0] w;
      int ones = 0;
      w = 32'b01_01_00001_00100_10_1010_0101_1100_0011;
      @(posedge MDC); #1;
      b32.REQ0_WR = 1'b1; b32.REQ0_PHYAD = 5'h01; b32.REQ0_REGAD = 5'h04; b32.REQ0_WDATA = 16'hA5C3;
      b32.REQ0_VALID = 1'b1;
      @(posedge MDC); #1 b32.REQ0_VALID = 1'b0;
      capture(1'b0, 66, 1'b0, 16'h0);
      for (int j = 0; j < 66; j++) begin
         logic eo, eout;
         eo   = (j < 64);
         eout = (j < 32) ? 1'b1 : (j < 64) ? w[63-j] : 1'b1;
         if (c_oe[j]) ones++;
         vec_cnt++; if (c_oe[j] !== eo)   begin err_cnt++; $display("FAIL wr_oe cyc=%0d got=%b exp=%b", j, c_oe[j], eo); end
         vec_cnt++; if (c_out[j] !== eout) begin err_cnt++; $display("FAIL wr_out cyc=%0d got=%b exp=%b", j, c_out[j], eout); end
         vec_cnt++; if (c_d0[j] !== (j == 64)) begin err_cnt++; $display("FAIL wr_done0 cyc=%0d got=%b exp=%b", j, c_d0[j], (j == 64)); end
         vec_cnt++; if (c_busy[j] !== (j <= 64)) begin err_cnt++; $display("FAIL wr_busy cyc=%0d got=%b exp=%b", j, c_busy[j], (j <= 64)); end
      end
      vec_cnt++; if (ones != 64) begin err_cnt++; $display("FAIL wr_oe_count got=%0d exp=64", ones); end
      vec_cnt++; if (c_rdata[64] !== 16'h0) begin err_cnt++; $display("FAIL wr_rdata_unchanged got=%h exp=0000", c_rdata[64]); end
   endtask

   task automatic test_read;
      logic [31:0] w;
      w = frame_word(1'b0, 5'h02, 5'h1F, 16'h0);
      @(posedge MDC); #1;
      b32.REQ1_WR = 1'b0; b32.REQ1_PHYAD = 5'h02; b32.REQ1_REGAD = 5'h1F; b32.REQ1_WDATA = 16'hFFFF;
      b32.REQ1_VALID = 1'b1;
      @(posedge MDC); #1 b32.REQ1_VALID = 1'b0;
      capture(1'b0, 66, 1'b1, 16'h1234);
      for (int j = 0; j < 66; j++) begin
         logic eo, eout;
         eo   = (j < 46);
         eout = (j < 32) ? 1'b1 : (j < 64) ? w[63-j] : 1'b1;
         vec_cnt++; if (c_oe[j] !== eo)   begin err_cnt++; $display("FAIL rd_oe cyc=%0d got=%b exp=%b", j, c_oe[j], eo); end
         vec_cnt++; if (c_out[j] !== eout) begin err_cnt++; $display("FAIL rd_out cyc=%0d got=%b exp=%b", j, c_out[j], eout); end
         vec_cnt++; if (c_d1[j] !== (j == 64)) begin err_cnt++; $display("FAIL rd_done1 cyc=%0d got=%b exp=%b", j, c_d1[j], (j == 64)); end
         vec_cnt++; if (c_d0[j] !== 1'b0) begin err_cnt++; $display("FAIL rd_done0 cyc=%0d got=%b exp=0", j, c_d0[j]); end
      end
      vec_cnt++; if (c_rdata[64] !== 16'h1234) begin err_cnt++; $display("FAIL rd_rdata got=%h exp=1234", c_rdata[64]); end
   endtask

   task automatic test_arbitration;
      int f, s;
      @(posedge MDC); #1;
      b32.REQ0_WR = 1'b1; b32.REQ0_PHYAD = 5'h03; b32.REQ0_REGAD = 5'h01; b32.REQ0_WDATA = 16'h0F0F;
      b32.REQ1_WR = 1'b1; b32.REQ1_PHYAD = 5'h04; b32.REQ1_REGAD = 5'h02; b32.REQ1_WDATA = 16'hF0F0;
      b32.REQ0_VALID = 1'b1; b32.REQ1_VALID = 1'b1;
      wait_dones(2, f, s);
      vec_cnt++; if (f !== 0) begin err_cnt++; $display("FAIL arb_r1_first got=%0d exp=0", f); end
      vec_cnt++; if (s !== 1) begin err_cnt++; $display("FAIL arb_r1_second got=%0d exp=1", s); end
      @(posedge MDC); #1 b32.REQ0_VALID = 1'b1;
      wait_dones(1, f, s);
      vec_cnt++; if (f !== 0) begin err_cnt++; $display("FAIL arb_solo got=%0d exp=0", f); end
      @(posedge MDC); #1 b32.REQ0_VALID = 1'b1; b32.REQ1_VALID = 1'b1;
      wait_dones(2, f, s);
      vec_cnt++; if (f !== 1) begin err_cnt++; $display("FAIL arb_r2_first got=%0d exp=1", f); end
      vec_cnt++; if (s !== 0) begin err_cnt++; $display("FAIL arb_r2_second got=%0d exp=0", s); end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] w;
      @(posedge MDC); #1;
      b32.REQ0_WR = 1'b1; b32.REQ0_PHYAD = 5'h03; b32.REQ0_REGAD = 5'h05; b32.REQ0_WDATA = 16'hBEEF;
      b32.REQ0_VALID = 1'b1;
      @(posedge MDC); #1 b32.REQ0_VALID = 1'b0;
      for (int j = 0; j <= 38; j++) begin
         @(negedge MDC);
         vec_cnt++; if (b32.REQ0_DONE !== 1'b0) begin err_cnt++; $display("FAIL abort_early_done cyc=%0d got=%b exp=0", j, b32.REQ0_DONE); end
      end
      vec_cnt++; if (b32.MDIO_OE !== 1'b1) begin err_cnt++; $display("FAIL abort_hdr_oe got=%b exp=1", b32.MDIO_OE); end
      RESET = 1'b0;
      @(negedge MDC);
      vec_cnt++; if (b32.MDIO_OE !== 1'b0)  begin err_cnt++; $display("FAIL abort_oe got=%b exp=0", b32.MDIO_OE); end
      vec_cnt++; if (b32.MDIO_OUT !== 1'b1) begin err_cnt++; $display("FAIL abort_out got=%b exp=1", b32.MDIO_OUT); end
      vec_cnt++; if ({b32.BUSY, b32.REQ0_DONE, b32.REQ1_DONE} !== 3'b000) begin err_cnt++; $display("FAIL abort_busy_done got=%b%b%b exp=000", b32.BUSY, b32.REQ0_DONE, b32.REQ1_DONE); end
      @(posedge MDC); #1 RESET = 1'b1; b32.REQ0_VALID = 1'b1;
      @(posedge MDC); #1 b32.REQ0_VALID = 1'b0;
      capture(1'b0, 66, 1'b0, 16'h0);
      w = frame_word(1'b1, 5'h03, 5'h05, 16'hBEEF);
      for (int j = 0; j < 66; j++) begin
         logic eo, eout;
         eo   = (j < 64);
         eout = (j < 32) ? 1'b1 : (j < 64) ? w[63-j] : 1'b1;
         vec_cnt++; if (c_oe[j] !== eo)   begin err_cnt++; $display("FAIL restart_oe cyc=%0d got=%b exp=%b", j, c_oe[j], eo); end
         vec_cnt++; if (c_out[j] !== eout) begin err_cnt++; $display("FAIL restart_out cyc=%0d got=%b exp=%b", j, c_out[j], eout); end
         vec_cnt++; if (c_d0[j] !== (j == 64)) begin err_cnt++; $display("FAIL restart_done0 cyc=%0d got=%b exp=%b", j, c_d0[j], (j == 64)); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] w0, w1;
      w0 = frame_word(1'b1, 5'h01, 5'h02, 16'h1357);
      w1 = frame_word(1'b1, 5'h1F, 5'h00, 16'h8001);
      @(posedge MDC); #1;
      b0.REQ0_WR = 1'b1; b0.REQ0_PHYAD = 5'h01; b0.REQ0_REGAD = 5'h02; b0.REQ0_WDATA = 16'h1357;
      b0.REQ1_WR = 1'b1; b0.REQ1_PHYAD = 5'h1F; b0.REQ1_REGAD = 5'h00; b0.REQ1_WDATA = 16'h8001;
      b0.REQ0_VALID = 1'b1; b0.REQ1_VALID = 1'b1;
      @(posedge MDC); #1 b0.REQ0_VALID = 1'b0;
      capture(1'b1, 68, 1'b0, 16'h0);
      for (int j = 0; j < 68; j++) begin
         logic eo, eout, eb;
         eo   = (j < 32) || (j >= 34 && j < 66);
         eout = (j < 32) ? w0[31-j] : (j >= 34 && j < 66) ? w1[65-j] : 1'b1;
         eb   = (j != 33) && (j != 67);
         vec_cnt++; if (c_oe[j] !== eo)   begin err_cnt++; $display("FAIL b2b_oe cyc=%0d got=%b exp=%b", j, c_oe[j], eo); end
         vec_cnt++; if (c_out[j] !== eout) begin err_cnt++; $display("FAIL b2b_out cyc=%0d got=%b exp=%b", j, c_out[j], eout); end
         vec_cnt++; if (c_d0[j] !== (j == 32)) begin err_cnt++; $display("FAIL b2b_done0 cyc=%0d got=%b exp=%b", j, c_d0[j], (j == 32)); end
         vec_cnt++; if (c_d1[j] !== (j == 66)) begin err_cnt++; $display("FAIL b2b_done1 cyc=%0d got=%b exp=%b", j, c_d1[j], (j == 66)); end
         vec_cnt++; if (c_busy[j] !== eb) begin err_cnt++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", j, c_busy[j], eb); end
      end
   endtask

   initial begin
      RESET = 1'b0;
      b32.REQ0_VALID = 1'b0; b32.REQ0_WR = 1'b0; b32.REQ0_PHYAD = '0; b32.REQ0_REGAD = '0; b32.REQ0_WDATA = '0;
      b32.REQ1_VALID = 1'b0; b32.REQ1_WR = 1'b0; b32.REQ1_PHYAD = '0; b32.REQ1_REGAD = '0; b32.REQ1_WDATA = '0;
      b32.MDIO_IN = 1'b1;
      b0.REQ0_VALID = 1'b0; b0.REQ0_WR = 1'b0; b0.REQ0_PHYAD = '0; b0.REQ0_REGAD = '0; b0.REQ0_WDATA = '0;
      b0.REQ1_VALID = 1'b0; b0.REQ1_WR = 1'b0; b0.REQ1_PHYAD = '0; b0.REQ1_REGAD = '0; b0.REQ1_WDATA = '0;
      b0.MDIO_IN = 1'b1;
      test_reset;
      test_write;
      test_read;
      test_arbitration;
      test_reset_midframe;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/mdio_mgmt_ctrl.md
Name: mdio_mgmt_ctrl

Overview:
- MDIO management master controller: it shares one MDIO line between two requesters (REQ0, REQ1) using round-robin arbitration.
- For the granted request it serializes a Clause-22 frame (optional preamble + 32-bit frame) onto MDIO_OUT/MDIO_OE, and captures read data from MDIO_IN.
- It is the counterpart of the PHY-side mdio receiver in the same design; both run on MDC.

Parameters:
- PRE_LEN, 32, number of preamble '1' bits sent before ST; legal range 0..32.

Ports:
- MDC  input  1  clock; all logic on posedge MDC.
- RESET  input  1  reset, synchronous, active-low.
- REQ0_VALID  input  1  requester 0 has a transaction pending.
- REQ0_WR  input  1  requester 0 op: 1 = write, 0 = read.
- REQ0_PHYAD  input  5  requester 0 PHY address.
- REQ0_REGAD  input  5  requester 0 register address.
- REQ0_WDATA  input  16  requester 0 write data.
- REQ0_DONE  output  1  one-cycle completion pulse to requester 0.
- REQ1_VALID, REQ1_WR, REQ1_PHYAD, REQ1_REGAD, REQ1_WDATA, REQ1_DONE  same as REQ0_*, for requester 1.
- RDATA  output  16  read data; valid when the DONE of a read pulses.
- BUSY  output  1  high from grant until DONE inclusive.
- MDIO_OUT  output  1  serial data to the PHY side.
- MDIO_OE  output  1  MDIO_OUT drive enable.
- MDIO_IN  input  1  serial data from the PHY side.

Behaviour:
- Reset values (any posedge with RESET=0): REQx_DONE=0, RDATA=16'h0, BUSY=0, MDIO_OUT=1, MDIO_OE=0, state=IDLE, last_grant=1.
- Reset mid-frame aborts the frame. On that posedge OE drops and MDIO_OUT goes to 1; no DONE is issued.
- Frame bit order, MSB first:
  - ST = 01
  - OP = 01 for write, 10 for read
  - PHYAD[4:0], REGAD[4:0]
  - TA
  - DATA[15:0]
- TA: driven 10 on writes; on reads OE is low for the 2 TA cycles and the 16 data cycles.
- States: IDLE -> PRE -> HDR -> TA -> DATA -> DONE -> IDLE.
  - PRE is skipped when PRE_LEN=0.
  - A 6-bit bit counter is cleared on every state entry.
- IDLE:
  - MDIO_OE=0, MDIO_OUT=1.
  - At a posedge where any VALID=1: grant, latch that requester's WR/PHYAD/REGAD/WDATA, BUSY<=1, go to PRE (or HDR).
- Arbitration: if only one VALID is high it wins. If both are high, the requester != last_grant wins. last_grant updates at grant.
- Bit timing: each frame bit is held on MDIO_OUT for exactly one MDC cycle, and is updated at the posedge that ends the previous bit. The first preamble bit appears in the cycle following the grant edge.
- PRE: OE=1, OUT=1 for PRE_LEN cycles.
- HDR: OE=1, 14 cycles (ST, OP, PHYAD, REGAD).
- TA:
  - Write: OE=1, OUT=1 then 0.
  - Read: OE=0, OUT=1.
- DATA, 16 cycles:
  - Write: OE=1, OUT=WDATA[15-i].
  - Read: OE=0; MDIO_IN is sampled at the posedge ending each data-bit cycle and shifted into a capture register, MSB first.
- DONE, one cycle:
  - OE=0, OUT=1.
  - The granted REQx_DONE=1.
  - On reads, RDATA<=capture register, loaded at the edge entering DONE.
  - On writes, RDATA is unchanged.
  - BUSY stays 1. Next state is IDLE, with BUSY<=0 and DONE<=0.
- Total latency from grant edge to DONE high: PRE_LEN+32+1 cycles.
- Requester rule: hold VALID and fields stable until DONE, and drive VALID low in the cycle after DONE. A VALID still high at the IDLE sampling edge is treated as a new request.
- VALID deasserted after grant has no effect; the frame completes.
- A requester with VALID high and not granted waits; there is no timeout and no starvation (alternation guarantees service within one frame).

Decomposition:
- mdio_pkg holds:
  - state encodings
  - ST_CODE=2'b01, OP_WR=2'b01, OP_RD=2'b10, TA_WR=2'b10
  - field lengths: HDR_BITS=14, TA_BITS=2, DATA_BITS=16
- Sub-module mdio_rr_arbiter: 2-way round-robin with inputs req[1:0] and a load enable; outputs a grant index and last_grant state.

Test Plan:
1. Reset: hold RESET=0 for 3 cycles with both VALID=1 -> OE=0, MDIO_OUT=1, BUSY=0, DONE=0, RDATA=0.
2. PRE_LEN=32, REQ0 write PHYAD=5'h01, REGAD=5'h04, WDATA=16'hA5C3 -> the following 66 bits on MDIO_OUT, then REQ0_DONE pulses at grant+65:
   - 32 ones
   - 01 01 00001 00100 10
   - 1010010111000011
   Check: OE=1 for exactly 64 cycles.
3. REQ1 read PHYAD=5'h02, REGAD=5'h1F, bench drives 16'h1234 on MDIO_IN in the data cycles -> OE=1 through the REGAD bits then 0 for 18 cycles, RDATA=16'h1234 with REQ1_DONE, REQ0_DONE stays 0.
4. Both VALID high right after reset -> REQ0 served first, then REQ1. Both high again -> REQ1 served first. Check the DONE order each time.
5. RESET=0 during HDR bit 6 -> at that edge OE=0, OUT=1, no DONE; after release, a new REQ0 frame starts cleanly from preamble bit 0.
6. PRE_LEN=0, REQ0 write immediately followed by a REQ1 write -> ST appears in the cycle after each grant; one idle cycle plus one DONE cycle between frames.
